// File: rtl/alu_op_driver.sv
// alu_op_driver
// Initiator side of the Mini SRC ALU interface. It takes one operation
// request, drives the ALU y/b/control inputs and holds them for a fixed
// number of cycles, captures the 64-bit ALU result into Z, and then returns
// it as register-file writeback beats: one beat to Rd for single-word ops,
// or two beats (LO then HI) for MUL/DIV. At most one operation is in flight.
//
// Handshakes (both channels use strict valid/ready semantics):
//   A transfer happens on a rising clock edge where valid && ready are both 1.
//   req_*: req_ready is 1 only in IDLE. req_valid seen while busy is ignored,
//          not queued. A request may be accepted in the same cycle that
//          req_ready returns to 1.
//   wb_*:  once wb_valid rises, wb_valid/wb_sel/wb_reg/wb_data stay constant
//          until the edge where wb_ready is also 1. Backpressure may last
//          any number of cycles.
//
// ALU_CYCLES and MULDIV_CYCLES must lie in 1..15. The ALU updates its result
// on the falling clock edge, so a capture at least one full cycle after the
// operands change always sees a result computed from those operands.

module alu_op_driver #(
    parameter int unsigned ALU_CYCLES    = 1,
    parameter int unsigned MULDIV_CYCLES = 2,
    parameter int unsigned CNT_W         = 16
) (
    input  logic             clock,
    input  logic             clear,

    // Request channel
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [4:0]       req_op,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic [3:0]       req_rd,

    // ALU side
    output logic [31:0]      alu_y,
    output logic [31:0]      alu_b,
    output logic [4:0]       alu_control,
    input  logic [63:0]      alu_result,

    // Writeback channel
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [1:0]       wb_sel,
    output logic [3:0]       wb_reg,
    output logic [31:0]      wb_data,

    // Status
    output logic             err,
    output logic [CNT_W-1:0] op_count,

    // Debug: current FSM state (encoding of state_e below)
    output logic [2:0]       dbg_state
);

    // ------------------------------------------------------------------
    // Opcodes understood by the Mini SRC ALU
    // ------------------------------------------------------------------
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_SHR  = 5'b00101;
    localparam logic [4:0] OP_SHRA = 5'b00110;
    localparam logic [4:0] OP_SHL  = 5'b00111;
    localparam logic [4:0] OP_ROR  = 5'b01000;
    localparam logic [4:0] OP_ROL  = 5'b01001;
    localparam logic [4:0] OP_AND  = 5'b01010;
    localparam logic [4:0] OP_OR   = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_INC  = 5'b11111;

    // Writeback destination select
    localparam logic [1:0] SEL_RD = 2'b00;
    localparam logic [1:0] SEL_LO = 2'b01;
    localparam logic [1:0] SEL_HI = 2'b10;

    // Wait-counter reload values (4 bits covers the legal 1..15 range)
    localparam logic [3:0] WAIT_ALU    = 4'(ALU_CYCLES);
    localparam logic [3:0] WAIT_MULDIV = 4'(MULDIV_CYCLES);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_EXEC  = 3'd1,
        ST_WB_RD = 3'd2,
        ST_WB_LO = 3'd3,
        ST_WB_HI = 3'd4
    } state_e;

    // ------------------------------------------------------------------
    // Opcode classification
    // ------------------------------------------------------------------
    function automatic logic op_is_muldiv(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

    function automatic logic op_is_single(input logic [4:0] op);
        logic hit;
        case (op)
            OP_ADD, OP_SUB, OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL,
            OP_AND, OP_OR, OP_NEG, OP_NOT, OP_INC: hit = 1'b1;
            default:                               hit = 1'b0;
        endcase
        return hit;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e           state_q;
    logic [3:0]       wait_q;        // cycles left until result capture
    logic             muldiv_q;      // in-flight op returns two beats
    logic [3:0]       rd_q;          // latched destination register
    logic [31:0]      alu_y_q;
    logic [31:0]      alu_b_q;
    logic [4:0]       alu_ctrl_q;
    logic [63:0]      z_q;           // captured ALU result
    logic             wb_valid_q;
    logic [1:0]       wb_sel_q;
    logic [3:0]       wb_reg_q;
    logic             err_q;
    logic [CNT_W-1:0] op_count_q;

    // Decoded request, evaluated only when a request is offered in IDLE
    logic             accept_d;
    logic             req_single_d;
    logic             req_muldiv_d;
    logic             req_supported_d;
    logic [3:0]       wait_load_d;
    logic             wb_fire_d;
    logic [CNT_W-1:0] op_count_inc_d;

    // Decode the incoming request and the writeback handshake
    always_comb begin
        accept_d        = req_valid && (state_q == ST_IDLE);
        req_single_d    = op_is_single(req_op);
        req_muldiv_d    = op_is_muldiv(req_op);
        req_supported_d = req_single_d || req_muldiv_d;
        wait_load_d     = req_muldiv_d ? WAIT_MULDIV : WAIT_ALU;
        wb_fire_d       = wb_valid_q && wb_ready;
        op_count_inc_d  = op_count_q + CNT_W'(1);
    end

    // Operation FSM with registered ALU drive, writeback and status outputs
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q    <= ST_IDLE;
            wait_q     <= 4'd0;
            muldiv_q   <= 1'b0;
            rd_q       <= 4'd0;
            alu_y_q    <= 32'd0;
            alu_b_q    <= 32'd0;
            alu_ctrl_q <= 5'b00000;
            z_q        <= 64'd0;
            wb_valid_q <= 1'b0;
            wb_sel_q   <= SEL_RD;
            wb_reg_q   <= 4'd0;
            err_q      <= 1'b0;
            op_count_q <= '0;
        end else begin
            // err is a single-cycle pulse unless re-armed below
            err_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (accept_d) begin
                        if (req_supported_d) begin
                            alu_y_q    <= req_a;
                            alu_b_q    <= req_b;
                            alu_ctrl_q <= req_op;
                            rd_q       <= req_rd;
                            muldiv_q   <= req_muldiv_d;
                            wait_q     <= wait_load_d;
                            state_q    <= ST_EXEC;
                        end else begin
                            // Rejected: ALU drive untouched, no writeback
                            err_q <= 1'b1;
                        end
                    end
                end

                ST_EXEC: begin
                    // A count of 0 can only come from an illegal parameter;
                    // treat it like 1 so the FSM can never stall here.
                    if (wait_q <= 4'd1) begin
                        z_q        <= alu_result;
                        wait_q     <= 4'd0;
                        wb_valid_q <= 1'b1;
                        if (muldiv_q) begin
                            wb_sel_q <= SEL_LO;
                            wb_reg_q <= 4'd0;
                            state_q  <= ST_WB_LO;
                        end else begin
                            wb_sel_q <= SEL_RD;
                            wb_reg_q <= rd_q;
                            state_q  <= ST_WB_RD;
                        end
                    end else begin
                        wait_q <= wait_q - 4'd1;
                    end
                end

                ST_WB_RD: begin
                    if (wb_fire_d) begin
                        wb_valid_q <= 1'b0;
                        wb_sel_q   <= SEL_RD;
                        wb_reg_q   <= 4'd0;
                        op_count_q <= op_count_inc_d;
                        state_q    <= ST_IDLE;
                    end
                end

                ST_WB_LO: begin
                    if (wb_fire_d) begin
                        wb_sel_q <= SEL_HI;
                        state_q  <= ST_WB_HI;
                    end
                end

                ST_WB_HI: begin
                    if (wb_fire_d) begin
                        wb_valid_q <= 1'b0;
                        wb_sel_q   <= SEL_RD;
                        wb_reg_q   <= 4'd0;
                        op_count_q <= op_count_inc_d;
                        state_q    <= ST_IDLE;
                    end
                end

                default: begin
                    wb_valid_q <= 1'b0;
                    state_q    <= ST_IDLE;
                end
            endcase
        end
    end

    // Drive outputs; wb_data is a pure select over registers so it is stable
    // for as long as wb_sel and Z are, and reads 0 whenever no beat is present
    always_comb begin
        req_ready   = (state_q == ST_IDLE);
        alu_y       = alu_y_q;
        alu_b       = alu_b_q;
        alu_control = alu_ctrl_q;
        wb_valid    = wb_valid_q;
        wb_sel      = wb_sel_q;
        wb_reg      = wb_reg_q;
        wb_data     = 32'd0;
        if (wb_valid_q) begin
            wb_data = (wb_sel_q == SEL_HI) ? z_q[63:32] : z_q[31:0];
        end
        err         = err_q;
        op_count    = op_count_q;
        dbg_state   = state_q;
    end

endmodule
